// File: rtl/q_8_28_restoring_div.sv
// Unsigned restoring divider: one quotient bit per SHIFT/SUB cycle pair, one-hot controller.
// Latency: 2*dp_width cycles from the accepting edge to rdy; divide-by-zero resolves in 0 cycles.
// Backpressure: start is only honoured while rdy=1; requests while busy are dropped, not queued.
module q_8_28_restoring_div #(
    parameter int dp_width = 8,
    parameter int bc_size  = $clog2(dp_width + 1)
) (
    input  logic                clk,
    input  logic                rst_b,
    input  logic                start,
    input  logic [dp_width-1:0] dividend,
    input  logic [dp_width-1:0] divisor,
    output logic [dp_width-1:0] quotient,
    output logic [dp_width-1:0] remainder,
    output logic                rdy,
    output logic                div_by_zero
);

    // One flip-flop per state: bit 0 = G0 IDLE, bit 1 = G1 SHIFT, bit 2 = G2 SUB.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'b001,
        ST_SHIFT = 3'b010,
        ST_SUB   = 3'b100
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Datapath registers. A carries one guard bit so the trial subtract
    // can see a shifted partial remainder of up to 2*B-1.
    logic [dp_width:0]   r_a;
    logic [dp_width-1:0] r_q;
    logic [dp_width-1:0] r_b;
    logic [bc_size-1:0]  r_p;
    logic                r_dz;

    // Combinational helpers for the datapath.
    logic                w_accept;
    logic                w_div_zero_req;
    logic [dp_width:0]   w_a_sh;
    logic [dp_width-1:0] w_q_sh;
    logic [dp_width:0]   w_b_ext;
    logic                w_a_ge_b;
    logic [dp_width:0]   w_a_diff;
    logic [bc_size-1:0]  w_p_dec;
    logic                w_p_zero;

    assign w_accept       = (r_state == ST_IDLE) && start;
    assign w_div_zero_req = (divisor == '0);

    // Left shift of the {A,Q} pair; A's guard bit is always 0 when a shift
    // starts (the previous SUB left A < B), so dropping it loses nothing.
    assign {w_a_sh, w_q_sh} = {r_a[dp_width-1:0], r_q, 1'b0};

    // Unsigned trial subtract on dp_width+1 bits; only committed when A >= B.
    assign w_b_ext  = {1'b0, r_b};
    assign w_a_ge_b = (r_a >= w_b_ext);
    assign w_a_diff = r_a - w_b_ext;

    assign w_p_dec  = r_p - {{(bc_size-1){1'b0}}, 1'b1};
    assign w_p_zero = (r_p == '0);

    // State register: asynchronous abort back to IDLE.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; any non-one-hot encoding falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !w_div_zero_req) begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                w_state_nxt = ST_SUB;
            end
            ST_SUB: begin
                // P was already decremented by the SHIFT of this pair, so
                // zero here means the last quotient bit has just been resolved.
                if (w_p_zero) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath: load on accept, shift on SHIFT, conditional restore-free subtract on SUB.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_a  <= '0;
            r_q  <= '0;
            r_b  <= '0;
            r_p  <= bc_size'(dp_width);
            r_dz <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (w_div_zero_req) begin
                            // Resolved without iterating: all-ones quotient,
                            // dividend passed through as the remainder.
                            r_a  <= {1'b0, dividend};
                            r_q  <= '1;
                            r_dz <= 1'b1;
                        end else begin
                            r_a  <= '0;
                            r_q  <= dividend;
                            r_b  <= divisor;
                            r_p  <= bc_size'(dp_width);
                            r_dz <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    r_a <= w_a_sh;
                    r_q <= w_q_sh;
                    r_p <= w_p_dec;
                end
                ST_SUB: begin
                    if (w_a_ge_b) begin
                        r_a    <= w_a_diff;
                        r_q[0] <= 1'b1;
                    end
                end
                default: begin
                    r_a <= r_a;
                end
            endcase
        end
    end

    assign quotient    = r_q;
    assign remainder   = r_a[dp_width-1:0];
    assign rdy         = (r_state == ST_IDLE);
    assign div_by_zero = r_dz;

endmodule

// File: doc/q_8_28_restoring_div.md
# q_8_28_restoring_div

Sequential unsigned restoring divider, the inverse of the team's shift-add multiplier. A one-hot controller and a shift-subtract datapath process one quotient bit per two clock cycles. It is the divide companion to the multiplier in the arithmetic unit and uses the same start/rdy handshake, so the two are interchangeable from the sequencer's side.

## Interface
Parameters:
- `dp_width`, default 8: operand width in bits. Legal range is 2..16.
- `bc_size`, default `$clog2(dp_width+1)`: width of the iteration counter P.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `rst_b`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: request a divide. Sampled only while `rdy`=1.
- `dividend`, in, `dp_width`: unsigned dividend. Sampled on the accepting edge only.
- `divisor`, in, `dp_width`: unsigned divisor. Sampled on the accepting edge only.
- `quotient`, out, `dp_width`: result quotient.
- `remainder`, out, `dp_width`: result remainder.
- `rdy`, out, 1: 1 when idle. Results are valid whenever `rdy`=1 after at least one completed operation.
- `div_by_zero`, out, 1: set when the last accepted request had `divisor`=0.

## Operation
One-hot state register with three flip-flops:
- G0 IDLE resets to 1.
- G1 SHIFT resets to 0.
- G2 SUB resets to 0.

Registers:
- A, `dp_width`+1 bits: partial remainder.
- Q, `dp_width` bits: dividend/quotient.
- B, `dp_width` bits: divisor.
- P, `bc_size` bits: iteration counter.
- DZ, 1 bit: divide-by-zero flag.

Outputs:
- `quotient` = Q.
- `remainder` = A[`dp_width`-1:0].
- `rdy` = G0.
- `div_by_zero` = DZ.

Reset values: A=0, Q=0, B=0, P=`dp_width`, DZ=0, so `quotient`=0, `remainder`=0, `rdy`=1, `div_by_zero`=0.

State transitions and actions:
- **IDLE, `start`=1, `divisor`≠0:** load A=0, Q=`dividend`, B=`divisor`, P=`dp_width`, DZ=0. Next state SHIFT.
- **IDLE, `start`=1, `divisor`=0:** load Q=all ones, A={0,`dividend`}, DZ=1. Stay in IDLE; no iterations run.
- **IDLE, `start`=0:** hold all registers. Stay in IDLE.
- **SHIFT:** {A,Q} <= {A,Q} << 1, filling Q[0] with 0. P <= P-1. Next state SUB.
- **SUB:** if A ≥ {0,B}, then A <= A - {0,B} and Q[0] <= 1; otherwise A and Q hold. If P==0, next state IDLE; otherwise next state SHIFT.

Arithmetic rules:
- The comparison is unsigned, on `dp_width`+1 bits.
- A never exceeds 2·B-1 after a shift, so the extra bit is sufficient and the subtraction never underflows.
- Final results satisfy `dividend` = `quotient`·`divisor` + `remainder`, with `remainder` < `divisor`.

Boundary conditions:
- `start` while busy (G1 or G2) is ignored. Inputs are not re-sampled and the operation is not restarted.
- `start` held high through completion starts a new operation on the first edge where `rdy`=1. Back-to-back operations lose no cycles.
- Inputs may change freely after the accepting edge.
- Asserting `rst_b` mid-operation aborts immediately and asynchronously to reset values, with G0=1. There is no partial result.
- Exactly one of G0/G1/G2 is 1 at all times out of reset.
- `dividend`=0 yields 0/0 remainder 0 after the full iteration count; there is no early exit.

## Timing
- Accepting edge: the edge where `rdy`=1 and `start`=1 (call it edge 0).
- Divisor ≠ 0:
  - `rdy` drops after edge 0.
  - Edges 1..2·`dp_width` alternate SHIFT/SUB.
  - `rdy` returns to 1 after edge 2·`dp_width` (16 cycles for the default width), with final `quotient`/`remainder` valid in the same cycle.
- Divisor = 0: `rdy` stays 1. `quotient`=all ones, `remainder`=`dividend`, and `div_by_zero`=1 are visible after edge 0.
- Results and `div_by_zero` hold until the next accepting edge or reset.
- Intermediate values of `quotient`/`remainder` while `rdy`=0 are unspecified to users.

## Test plan
All cases use `dp_width`=8.
- **Reset:** apply reset, release, idle 3 cycles -> `rdy`=1, `quotient`=0, `remainder`=0, `div_by_zero`=0.
- **Basic divides:** 100/7 -> `quotient`=14, `remainder`=2, `rdy` high exactly 16 cycles after accept.
- **Corner divides, back-to-back with `start` held high:**
  - 255/1 -> 255 r 0.
  - 5/9 -> 0 r 5.
  - 255/255 -> 1 r 0.
  - 0/3 -> 0 r 0.
  - No idle gap between operations.
- **Divide by zero:** 200/0 -> `rdy` never drops, `quotient`=255, `remainder`=200, `div_by_zero`=1. A following 9/4 clears it -> 2 r 1, `div_by_zero`=0.
- **Busy-start and input changes:** pulse `start` with new operands at cycles 3 and 9 of a 100/7 operation -> ignored, result still 14 r 2.
- **Reset mid-operation:** assert `rst_b` at cycle 5 of 200/3 -> outputs at reset values immediately. A subsequent 200/3 -> 66 r 2.
- **Exhaustive sweep:** all 65536 dividend/divisor pairs checked against a reference model. One-hot invariant asserted every cycle.
